// File: rtl/fifo_narrow_to_wide.sv
// Asymmetric show-ahead FIFO: DATA_WIDTH-bit writes, 2*DATA_WIDTH-bit reads.
// The earlier-written narrow word occupies the low half of the wide read word.
module fifo_narrow_to_wide #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    rd,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    full,
    output logic                    empty,
    output logic [ADDR_WIDTH:0]     level
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr_hi;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    // Requests against the flags are dropped silently.
    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count < CW'(2));
    assign level = count;

    // r_ptr is always even, so the partner entry never wraps unaligned.
    assign r_ptr_hi = r_ptr + ADDR_WIDTH'(1);
    assign r_data   = {mem[r_ptr_hi], mem[r_ptr]};

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(2);
            2'b11:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            count <= count_nxt;
            if (wr_acc) begin
                w_ptr <= w_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + ADDR_WIDTH'(2);
            end
        end
    end

    // Storage is cleared on reset so r_data reads zero until refilled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '{default: '0};
        end else if (wr_acc) begin
            mem[w_ptr] <= w_data;
        end
    end

endmodule

// File: tb/tb_fifo_narrow_to_wide.sv
// Scoreboard bench for fifo_narrow_to_wide: queue-of-nibbles reference model,
// expected wide words pushed on predicted pops, compared by a negedge monitor.
module tb_fifo_narrow_to_wide;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 4;
    localparam int          DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr;
    logic [DW-1:0] w_data;
    logic          rd;
    logic [2*DW-1:0] r_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]   model[$];
    logic [2*DW-1:0] exp_q[$];
    int              exp_level = 0;

    fifo_narrow_to_wide #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr),
        .w_data  (w_data),
        .rd      (rd),
        .r_data  (r_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Drive one cycle of requests and advance the reference model for the coming edge.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        bit wa;
        bit ra;
        @(posedge clk);
        #1;
        wr        = w;
        rd        = r;
        w_data    = d;
        exp_level = model.size();
        wa = w && (model.size() < DEPTH);
        ra = r && (model.size() >= 2);
        if (ra) begin
            exp_q.push_back({model[1], model[0]});
            void'(model.pop_front());
            void'(model.pop_front());
        end
        if (wa) model.push_back(d);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0);
    endtask

    // Monitor: flags every cycle, and the popped word whenever a pop is presented.
    always @(negedge clk) begin
        if (reset_n) begin
            check("level", int'(level), exp_level);
            check("empty", int'(empty), int'(exp_level < 2));
            check("full", int'(full), int'(exp_level == DEPTH));
            if (rd && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no pop", r_data);
                end else begin
                    check("pop_data", int'(r_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        w_data  = '0;
        #2;
        check("rst_r_data", int'(r_data), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_level", int'(level), 0);
        #10;
        reset_n = 1'b1;

        // Reads on an empty FIFO move nothing.
        repeat (4) cycle(1'b0, 1'b1, '0);
        idle();
        check("t1_r_data", int'(r_data), 8'h00);
        check("t1_level", int'(level), 0);

        // A and 5 pack as 5A.
        cycle(1'b1, 1'b0, 4'hA);
        idle();
        check("t2_lone_empty", int'(empty), 1);
        check("t2_lone_level", int'(level), 1);
        cycle(1'b1, 1'b0, 4'h5);
        idle();
        check("t2_r_data", int'(r_data), 8'h5A);
        check("t2_empty", int'(empty), 0);
        cycle(1'b0, 1'b1, '0);
        idle();
        check("t2_drained", int'(level), 0);

        // Fill to full; ninth write is dropped.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 4'(i));
        cycle(1'b1, 1'b0, 4'hF);
        idle();
        check("t3_full", int'(full), 1);
        check("t3_level", int'(level), 8);
        check("t3_head", int'(r_data), 8'h21);
        repeat (4) cycle(1'b0, 1'b1, '0);
        idle();
        check("t3_empty", int'(empty), 1);

        // Simultaneous wr/rd at level 7 and at full.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 4'(i + 3));
        idle();
        check("t4_head7", int'(r_data), 8'h43);
        cycle(1'b1, 1'b1, 4'hE);
        idle();
        check("t4_level6", int'(level), 6);
        check("t4_head_adv", int'(r_data), 8'h65);
        cycle(1'b1, 1'b0, 4'hD);
        cycle(1'b1, 1'b0, 4'hC);
        idle();
        check("t4_full", int'(level), 8);
        cycle(1'b1, 1'b1, 4'h1);
        idle();
        check("t4_full_wr_rd", int'(level), 6);
        repeat (3) cycle(1'b0, 1'b1, '0);
        idle();
        check("t4_drained", int'(level), 0);

        // Random streaming: pointers wrap many times.
        for (int i = 0; i < 400; i++) begin
            cycle(1'(($urandom % 3) != 0), 1'(($urandom % 2) == 0), 4'($urandom));
        end
        for (int i = 0; i < 8 && model.size() >= 2; i++) cycle(1'b0, 1'b1, '0);
        idle();
        idle();
        check("stream_level", int'(level), model.size());
        check("stream_scoreboard_drained", exp_q.size(), 0);

        // Drop any leftover nibble, then reach level 5 and reset mid-cycle.
        if (model.size() == 1) cycle(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 8 && model.size() >= 2; i++) cycle(1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'(i + 9));
        idle();
        check("t6_level5", int'(level), 5);
        @(negedge clk);
        #2;
        wr = 1'b0;
        rd = 1'b0;
        reset_n = 1'b0;
        model.delete();
        exp_q.delete();
        exp_level = 0;
        #1;
        check("t6_async_level", int'(level), 0);
        check("t6_async_empty", int'(empty), 1);
        check("t6_async_full", int'(full), 0);
        check("t6_async_r_data", int'(r_data), 0);
        #10;
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 4'h3);
        cycle(1'b1, 1'b0, 4'hC);
        idle();
        check("t6_r_data", int'(r_data), 8'hC3);
        check("t6_empty", int'(empty), 0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
